// File: rtl/icache.sv
`default_nettype none
// ============================================================================
//  Module      : icache
//  Description : Direct-mapped, read-only instruction cache with one 32-bit
//                word per frame. A hit returns the word combinationally in the
//                same cycle. A miss enters FILL, holds a word-aligned read
//                request to the memory controller until iwait drops, and then
//                writes the returned word into the frame.
//
//  Ports       : CLK       - clock, rising-edge
//                nRST      - asynchronous active-low reset
//                imemREN   - datapath instruction read request
//                imemaddr  - datapath instruction byte address
//                ihit      - imemload holds the requested word this cycle
//                imemload  - instruction word to the datapath (0 when no hit)
//                iREN      - read request to the memory controller
//                iaddr     - word-aligned memory read address (0 when idle)
//                iwait     - memory busy; iload is valid when low during iREN
//                iload     - word returned by the memory controller
//
//  Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             r_state;
    logic [29:0]        r_miss_word;      // word address of the pending miss
    logic               r_valid [SETS];
    logic [TAG_W-1:0]   r_tag   [SETS];
    logic [31:0]        r_data  [SETS];

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [IDX_W-1:0]   w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_unused_bits;

    // Byte offset within the word does not select anything.
    assign w_unused_bits = &{1'b0, imemaddr[1:0]};

    assign w_idx      = imemaddr[IDX_W+1:2];
    assign w_tag      = imemaddr[31:IDX_W+2];
    assign w_fill_idx = r_miss_word[IDX_W-1:0];
    assign w_fill_tag = r_miss_word[29:IDX_W];

    // Hits are only served from IDLE so a frame being refilled can never be
    // returned to the datapath mid-fill.
    assign w_hit = imemREN && (r_state == IDLE) && r_valid[w_idx]
                   && (r_tag[w_idx] == w_tag);

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'd0;

    // Both memory-side outputs derive only from registers, so iaddr is held
    // for the whole fill and an asynchronous reset drops iREN immediately.
    assign iREN  = (r_state == FILL);
    assign iaddr = (r_state == FILL) ? {r_miss_word, 2'b00} : 32'd0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_word <= '0;
            for (int i = 0; i < SETS; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (imemREN && !w_hit) begin
                        r_state     <= FILL;
                        r_miss_word <= imemaddr[31:2];
                    end
                end
                FILL: begin
                    // Fill always runs to completion; datapath-side changes
                    // during FILL are ignored.
                    if (!iwait) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        r_tag[w_fill_idx]   <= w_fill_tag;
                        r_data[w_fill_idx]  <= iload;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache
//  Description : Scoreboard testbench for icache. A driver applies one set of
//                inputs per cycle, predicts the outputs from a frame-level
//                reference model and queues them; a monitor compares the DUT
//                outputs on the falling edge against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    localparam int SETS = 16;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    icache #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        hit;
        logic [31:0] load;
        logic        ren;
        logic [31:0] addr;
        int          ph;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   phase    = 0;

    // Reference model: each frame remembers which word address it holds.
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_fill;
    logic [31:0] m_miss;

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) begin
            m_valid[i] = 1'b0;
            m_word[i]  = '0;
            m_data[i]  = '0;
        end
        m_fill = 1'b0;
        m_miss = '0;
    endtask

    // One clock cycle of stimulus; rst=1 holds nRST low for this cycle.
    task automatic cyc(input bit rst, input bit ren, input logic [31:0] a,
                       input bit w, input logic [31:0] ld);
        exp_t e;
        int   idx;
        @(posedge CLK);
        #1;
        nRST     = !rst;
        imemREN  = ren;
        imemaddr = a;
        iwait    = w;
        iload    = ld;
        e.ph = phase;
        if (rst) begin
            e.hit = 0; e.load = 0; e.ren = 0; e.addr = 0;
            model_clear();
        end else if (!m_fill) begin
            idx   = int'(a[31:2]) % SETS;
            e.hit = ren && m_valid[idx] && (m_word[idx] == a[31:2]);
            e.load = e.hit ? m_data[idx] : 32'd0;
            e.ren  = 0;
            e.addr = 0;
            if (ren && !e.hit) begin
                m_fill = 1'b1;
                m_miss = {a[31:2], 2'b00};
            end
        end else begin
            e.hit  = 0;
            e.load = 0;
            e.ren  = 1;
            e.addr = m_miss;
            if (!w) begin
                idx = int'(m_miss[31:2]) % SETS;
                m_valid[idx] = 1'b1;
                m_word[idx]  = m_miss[31:2];
                m_data[idx]  = ld;
                m_fill       = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    // Miss on a, `waits` busy cycles, then data arrives; then re-request a.
    task automatic fill_then_hit(input logic [31:0] a, input int waits,
                                 input logic [31:0] d);
        cyc(0, 1, a, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < waits; i++) cyc(0, 1, a, 1, $urandom);
        cyc(0, 1, a, 0, d);
        cyc(0, 1, a, 1, $urandom);
    endtask

    // Monitor
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (ihit !== e.hit || imemload !== e.load ||
                iREN !== e.ren || iaddr !== e.addr) begin
                failures++;
                $display("FAIL phase%0d t=%0t: got ihit=%b imemload=%h iREN=%b iaddr=%h, want ihit=%b imemload=%h iREN=%b iaddr=%h",
                         e.ph, $time, ihit, imemload, iREN, iaddr,
                         e.hit, e.load, e.ren, e.addr);
            end
        end
    end

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        model_clear();

        // Reset state, including a request while reset is held
        phase = 0;
        cyc(1, 0, 32'h0, 1, 32'h0);
        cyc(1, 1, 32'h40, 1, 32'h0);
        cyc(0, 0, 32'h40, 1, 32'h0);

        // Cold miss with three busy cycles, then warm hits
        phase = 1;
        fill_then_hit(32'h0000_0040, 3, 32'h2001_000A);
        phase = 2;
        cyc(0, 1, 32'h0000_0040, 1, 32'h0);
        cyc(0, 1, 32'h0000_0040, 0, 32'h0);

        // Conflict on index 0, then the old address misses again
        phase = 3;
        fill_then_hit(32'h0000_0080, 1, 32'h1234_5678);
        fill_then_hit(32'h0000_0040, 0, 32'h2001_000A);

        // Address change during fill
        phase = 4;
        cyc(0, 1, 32'h0000_0104, 1, 32'h0);
        cyc(0, 1, 32'h0000_0200, 1, 32'h0);
        cyc(0, 0, 32'h0000_0200, 1, 32'h0);
        cyc(0, 1, 32'h0000_0200, 0, 32'hCAFE_0104);
        cyc(0, 1, 32'h0000_0200, 0, 32'hCAFE_0200);
        cyc(0, 1, 32'h0000_0104, 1, 32'h0);
        cyc(0, 1, 32'h0000_0200, 1, 32'h0);

        // Reset mid-fill, then same address misses
        phase = 5;
        cyc(0, 1, 32'h0000_0300, 1, 32'h0);
        cyc(0, 1, 32'h0000_0300, 1, 32'h0);
        cyc(1, 1, 32'h0000_0300, 0, 32'h5555_AAAA);
        cyc(0, 1, 32'h0000_0300, 1, 32'h0);
        cyc(0, 1, 32'h0000_0300, 0, 32'h7777_0300);
        cyc(0, 1, 32'h0000_0300, 1, 32'h0);

        // Byte offset within a word hits the same frame
        phase = 6;
        fill_then_hit(32'h0000_0010, 2, 32'h0BAD_F00D);
        cyc(0, 1, 32'h0000_0013, 1, 32'h0);
        cyc(0, 1, 32'h0000_0011, 1, 32'h0);

        // Randomized traffic over a small address pool to get both hits and
        // conflicts, with the occasional high tag bit and reset.
        phase = 7;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) a = a | 32'h8000_0000;
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8), a,
                ($urandom_range(0, 1) == 1), $urandom);
        end

        cyc(0, 0, 32'h0, 1, 32'h0);
        repeat (3) @(posedge CLK);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses unchecked, want 0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
